// File: rtl/codec_pkg.sv
// Shared definitions for the codec control path: I2C master FSM states, frame
// layout constants and the register-word field widths used by the init sequencer.
package codec_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    localparam int REG_ADDR_W = 7;
    localparam int REG_VAL_W  = 9;
    localparam int REG_WORD_W = REG_ADDR_W + REG_VAL_W;

    // Address byte plus the two register-word bytes, shifted out MSB first.
    localparam int FRAME_W = 8 + REG_WORD_W;

    localparam logic [4:0] ACK_SLOT_0 = 5'd8;
    localparam logic [4:0] ACK_SLOT_1 = 5'd17;
    localparam logic [4:0] ACK_SLOT_2 = 5'd26;
    localparam logic [4:0] LAST_SLOT  = ACK_SLOT_2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BIT   = 2'd2,
        ST_STOP  = 2'd3
    } i2c_state_e;

    function automatic logic is_ack_slot(input logic [4:0] slot);
        return (slot == ACK_SLOT_0) || (slot == ACK_SLOT_1) || (slot == ACK_SLOT_2);
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-SCL-period tick divider: counts 0..CLK_DIV-1 while enabled and
// fires a single-cycle tick on the last count.
module i2c_qtick_gen #(
    parameter int CLK_DIV = 42
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic qtick_o
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("i2c_qtick_gen: CLK_DIV must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign qtick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/i2c_wr_master.sv
// Write-only I2C master: sends START, {DEV_ADDR,W}, data[15:8], data[7:0], STOP
// for each accepted go edge and reports whether any ACK slot saw a NACK.
module i2c_wr_master
    import codec_pkg::*;
#(
    parameter int         CLK_DIV  = 42,
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  go_i,
    input  logic [REG_WORD_W-1:0] data_i,
    output logic                  ready_o,
    output logic                  nack_o,
    output logic                  scl_o,
    inout  wire                   sda_io
);

    i2c_state_e       state_q, state_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic             nack_flag_q, nack_flag_d;
    logic             nack_q, nack_d;
    logic             ready_q, ready_d;
    logic             go_q, go_d;
    logic             scl_q, scl_d;
    logic             sda_rel_q, sda_rel_d;

    logic qtick;
    logic accept;
    logic sda_in;

    assign sda_in = sda_io;
    assign go_d   = go_i;
    assign accept = go_i & ~go_q & ready_q;

    i2c_qtick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q != ST_IDLE),
        .qtick_o (qtick)
    );

    // An accepted request parks one cycle in IDLE with ready low, then launches START.
    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        nack_flag_d = nack_flag_q;
        nack_d      = nack_q;
        ready_d     = ready_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d     = {DEV_ADDR, 1'b0, data_i};
                    nack_d      = 1'b0;
                    nack_flag_d = 1'b0;
                    ready_d     = 1'b0;
                end else if (!ready_q) begin
                    state_d = ST_START;
                    qtr_d   = 2'd0;
                end
            end

            ST_START: begin
                if (qtick) begin
                    if (qtr_q == 2'd3) begin
                        state_d   = ST_BIT;
                        qtr_d     = 2'd0;
                        bit_cnt_d = 5'd0;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end

            ST_BIT: begin
                if (qtick) begin
                    if ((qtr_q == 2'd2) && is_ack_slot(bit_cnt_q) && sda_in) begin
                        nack_flag_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        qtr_d = 2'd0;
                        if (!is_ack_slot(bit_cnt_q)) begin
                            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                        end
                        if (bit_cnt_q == LAST_SLOT) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end

            ST_STOP: begin
                if (qtick) begin
                    if (qtr_q == 2'd3) begin
                        state_d = ST_IDLE;
                        qtr_d   = 2'd0;
                        ready_d = 1'b1;
                        nack_d  = nack_flag_q;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus pins are registered from the upcoming phase so they change on the qtick edge.
    always_comb begin
        scl_d     = 1'b1;
        sda_rel_d = 1'b1;
        case (state_d)
            ST_START: begin
                scl_d     = (qtr_d != 2'd3);
                sda_rel_d = (qtr_d == 2'd0);
            end
            ST_BIT: begin
                scl_d     = qtr_d[1];
                sda_rel_d = is_ack_slot(bit_cnt_d) | shreg_d[FRAME_W-1];
            end
            ST_STOP: begin
                scl_d     = (qtr_d != 2'd0);
                sda_rel_d = qtr_d[1];
            end
            default: begin
                scl_d     = 1'b1;
                sda_rel_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            qtr_q       <= 2'd0;
            bit_cnt_q   <= 5'd0;
            shreg_q     <= '0;
            nack_flag_q <= 1'b0;
            nack_q      <= 1'b0;
            ready_q     <= 1'b1;
            go_q        <= 1'b0;
            scl_q       <= 1'b1;
            sda_rel_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            nack_flag_q <= nack_flag_d;
            nack_q      <= nack_d;
            ready_q     <= ready_d;
            go_q        <= go_d;
            scl_q       <= scl_d;
            sda_rel_q   <= sda_rel_d;
        end
    end

    assign ready_o = ready_q;
    assign nack_o  = nack_q;
    assign scl_o   = scl_q;
    assign sda_io  = sda_rel_q ? 1'bz : 1'b0;

endmodule
